// File: rtl/lsu_fault_pipe_pkg.sv
// Shared LSU fault-pipe types: the staged fault record, the capture-cause
// encodings and the capture FSM state type.
package lsu_fault_pipe_pkg;

  // The staged address field is a fixed 32 bits wide. Top-level ADDR_WIDTH
  // values up to 32 fit in it.
  localparam int LSU_ADDR_W = 32;

  typedef struct packed {
    logic                  fault;
    logic                  store;
    logic                  mis;
    logic [LSU_ADDR_W-1:0] addr;
  } lsu_fault_t;

  localparam logic [1:0] LSU_CAUSE_LD_ACC = 2'b00;
  localparam logic [1:0] LSU_CAUSE_LD_MIS = 2'b01;
  localparam logic [1:0] LSU_CAUSE_ST_ACC = 2'b10;
  localparam logic [1:0] LSU_CAUSE_ST_MIS = 2'b11;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_HELD = 1'b1
  } cap_state_e;

  // Map a staged fault record to its two-bit {store, misaligned} cause code.
  function automatic logic [1:0] lsu_cause(input lsu_fault_t f);
    if (f.store) return f.mis ? LSU_CAUSE_ST_MIS : LSU_CAUSE_ST_ACC;
    else         return f.mis ? LSU_CAUSE_LD_MIS : LSU_CAUSE_LD_ACC;
  endfunction

endpackage

// File: rtl/lsu_fault_pipe_if.sv
// Bundle of the LSU fault-pipe control, dc1 packet, dc3 exception and
// error-capture signals. The master side drives dc1 and the controls.
// The slave side is the fault pipe itself.
interface lsu_fault_pipe_if #(
  parameter int ADDR_WIDTH    = 32,
  parameter int OVF_CNT_WIDTH = 4
);
  logic                     lsu_freeze_dc3;
  logic                     flush_dc2_dc3;
  logic                     valid_dc1;
  logic                     store_dc1;
  logic                     dma_dc1;
  logic [ADDR_WIDTH-1:0]    start_addr_dc1;
  logic                     access_fault_dc1;
  logic                     misaligned_fault_dc1;
  logic                     exc_valid_dc3;
  logic                     exc_store_dc3;
  logic                     exc_misaligned_dc3;
  logic [ADDR_WIDTH-1:0]    exc_addr_dc3;
  logic                     err_valid;
  logic [1:0]               err_cause;
  logic [ADDR_WIDTH-1:0]    err_addr;
  logic                     err_ack;
  logic [OVF_CNT_WIDTH-1:0] err_ovf_cnt;

  modport master (
    output lsu_freeze_dc3, flush_dc2_dc3, valid_dc1, store_dc1, dma_dc1,
           start_addr_dc1, access_fault_dc1, misaligned_fault_dc1, err_ack,
    input  exc_valid_dc3, exc_store_dc3, exc_misaligned_dc3, exc_addr_dc3,
           err_valid, err_cause, err_addr, err_ovf_cnt
  );

  modport slave (
    input  lsu_freeze_dc3, flush_dc2_dc3, valid_dc1, store_dc1, dma_dc1,
           start_addr_dc1, access_fault_dc1, misaligned_fault_dc1, err_ack,
    output exc_valid_dc3, exc_store_dc3, exc_misaligned_dc3, exc_addr_dc3,
           err_valid, err_cause, err_addr, err_ovf_cnt
  );
endinterface

// File: rtl/lsu_fault_stage.sv
// One pipeline register for a staged LSU fault record.
// The hold input keeps the current occupant in place.
// The clear input kills a held occupant by dropping its fault bit.
// When the stage advances, the incoming record replaces the occupant, so
// the occupant is discarded anyway. The caller masks the incoming fault bit
// when the record that is moving in has been killed.
module lsu_fault_stage
  import lsu_fault_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       hold,
  input  logic       clear,
  input  lsu_fault_t d,
  output lsu_fault_t q
);

  // Advance, hold, or kill the held record.
  // NOTE: non-blocking (<=) so every register samples pre-edge values and
  // chained stages shift cleanly instead of racing through in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end else if (clear) begin
      q.fault <= 1'b0;
    end
  end

endmodule

// File: rtl/lsu_fault_pipe.sv
// LSU fault pipe.
// It qualifies the dc1 address-check faults and stages them through dc2 and
// dc3 under freeze and flush control. It presents one precise exception per
// instruction at dc3. It also keeps a sticky first-error capture register
// with an ack handshake and a saturating lost-error counter.
module lsu_fault_pipe
  import lsu_fault_pipe_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int OVF_CNT_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  lsu_fault_pipe_if.slave  bus
);

  lsu_fault_t dc1;
  lsu_fault_t dc2_q;
  lsu_fault_t dc3_d;
  lsu_fault_t dc3_q;
  logic       exc_fire;

  cap_state_e               state_q;
  logic                     err_valid_q;
  logic [1:0]               err_cause_q;
  logic [ADDR_WIDTH-1:0]    err_addr_q;
  logic [OVF_CNT_WIDTH-1:0] ovf_cnt_q;

  // Qualify dc1. DMA never faults here, and an access fault masks a
  // misaligned fault. A flushed dc2 record is killed as it moves into dc3.
  // NOTE: every field gets its value before any use, so no latch is inferred.
  always_comb begin
    dc1       = '0;
    dc1.fault = bus.valid_dc1 & ~bus.dma_dc1 &
                (bus.access_fault_dc1 | bus.misaligned_fault_dc1);
    dc1.store = bus.store_dc1;
    dc1.mis   = bus.misaligned_fault_dc1 & ~bus.access_fault_dc1;
    dc1.addr  = LSU_ADDR_W'(bus.start_addr_dc1);

    dc3_d       = dc2_q;
    dc3_d.fault = dc2_q.fault & ~bus.flush_dc2_dc3;
  end

  lsu_fault_stage u_dc2 (
    .clk   (clk),
    .rst   (rst),
    .hold  (bus.lsu_freeze_dc3),
    .clear (bus.flush_dc2_dc3),
    .d     (dc1),
    .q     (dc2_q)
  );

  lsu_fault_stage u_dc3 (
    .clk   (clk),
    .rst   (rst),
    .hold  (bus.lsu_freeze_dc3),
    .clear (bus.flush_dc2_dc3),
    .d     (dc3_d),
    .q     (dc3_q)
  );

  // The dc3 exception retires exactly once: on the edge it leaves dc3 unfrozen and unflushed.
  assign exc_fire = dc3_q.fault & ~bus.lsu_freeze_dc3 & ~bus.flush_dc2_dc3;

  // Capture FSM: keep the first error until it is acked, and count the errors lost meanwhile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CAP_IDLE;
      err_valid_q <= 1'b0;
      err_cause_q <= '0;
      err_addr_q  <= '0;
      ovf_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        CAP_IDLE: begin
          if (exc_fire) begin
            state_q     <= CAP_HELD;
            err_valid_q <= 1'b1;
            err_cause_q <= lsu_cause(dc3_q);
            err_addr_q  <= ADDR_WIDTH'(dc3_q.addr);
          end
        end
        CAP_HELD: begin
          if (exc_fire && bus.err_ack) begin
            err_cause_q <= lsu_cause(dc3_q);
            err_addr_q  <= ADDR_WIDTH'(dc3_q.addr);
          end else if (exc_fire) begin
            if (ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + OVF_CNT_WIDTH'(1);
          end else if (bus.err_ack) begin
            state_q     <= CAP_IDLE;
            err_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= CAP_IDLE;
          err_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.exc_valid_dc3      = dc3_q.fault;
  assign bus.exc_store_dc3      = dc3_q.store;
  assign bus.exc_misaligned_dc3 = dc3_q.mis;
  assign bus.exc_addr_dc3       = ADDR_WIDTH'(dc3_q.addr);
  assign bus.err_valid          = err_valid_q;
  assign bus.err_cause          = err_cause_q;
  assign bus.err_addr           = err_addr_q;
  assign bus.err_ovf_cnt        = ovf_cnt_q;

endmodule

// File: tb/tb_lsu_fault_pipe.sv
// Self-checking bench for lsu_fault_pipe.
// It applies a table of directed vectors, then hand-written multi-cycle
// sequences, then randomized traffic. Randomized traffic is checked against
// an instruction-level reference model.
module tb_lsu_fault_pipe;

  logic clk;
  logic rst;

  lsu_fault_pipe_if #(.ADDR_WIDTH(32), .OVF_CNT_WIDTH(4)) bus ();

  lsu_fault_pipe #(.ADDR_WIDTH(32), .OVF_CNT_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit        v, st, dma, acc, mis;
    bit [31:0] a;
    bit        frz, fl, ack;
  } in_t;

  typedef struct {
    bit        exc;
    bit        st, mis;
    bit [31:0] a;
    bit        ev;
    bit [1:0]  cause;
    bit [31:0] ea;
    bit [3:0]  ovf;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  typedef struct {
    bit        fault, store, mis;
    bit [31:0] addr;
  } item_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: an instruction in each of dc2 and dc3, plus the capture record.
  item_t     m_dc2, m_dc3;
  bit        m_held;
  bit [1:0]  m_cause;
  bit [31:0] m_addr;
  int        m_lost;

  function automatic in_t mk_in(bit v, bit st, bit dma, bit acc, bit mis, bit [31:0] a,
                                bit frz, bit fl, bit ack);
    in_t x;
    x.v = v; x.st = st; x.dma = dma; x.acc = acc; x.mis = mis; x.a = a;
    x.frz = frz; x.fl = fl; x.ack = ack;
    return x;
  endfunction

  function automatic exp_t mk_ex(bit exc, bit st, bit mis, bit [31:0] a,
                                 bit ev, bit [1:0] cause, bit [31:0] ea, bit [3:0] ovf);
    exp_t e;
    e.exc = exc; e.st = st; e.mis = mis; e.a = a;
    e.ev = ev; e.cause = cause; e.ea = ea; e.ovf = ovf;
    return e;
  endfunction

  function automatic in_t idle_in();
    return mk_in(0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_dc2 = '{default: 0};
    m_dc3 = '{default: 0};
    m_held = 0; m_cause = 0; m_addr = 0; m_lost = 0;
  endtask

  // One clock edge of the model, written from the instruction-level rules.
  task automatic model_step(input in_t x);
    item_t inc;
    bit    fire;
    fire = m_dc3.fault && !x.frz && !x.fl;
    inc.fault = x.v && !x.dma && (x.acc || x.mis);
    inc.store = x.st;
    inc.mis   = x.mis && !x.acc;
    inc.addr  = x.a;
    if (fire) begin
      if (!m_held || x.ack) begin
        m_held = 1; m_cause = {m_dc3.store, m_dc3.mis}; m_addr = m_dc3.addr;
      end else if (m_lost < 15) begin
        m_lost++;
      end
    end else if (x.ack) begin
      m_held = 0;
    end
    if (!x.frz) begin
      m_dc3 = m_dc2;
      if (x.fl) m_dc3.fault = 0;
      m_dc2 = inc;
    end else if (x.fl) begin
      m_dc2.fault = 0;
      m_dc3.fault = 0;
    end
  endtask

  task automatic drive(input in_t x);
    bus.valid_dc1            = x.v;
    bus.store_dc1            = x.st;
    bus.dma_dc1              = x.dma;
    bus.access_fault_dc1     = x.acc;
    bus.misaligned_fault_dc1 = x.mis;
    bus.start_addr_dc1       = x.a;
    bus.lsu_freeze_dc3       = x.frz;
    bus.flush_dc2_dc3        = x.fl;
    bus.err_ack              = x.ack;
  endtask

  // Drive one cycle, take the edge, sample 1 ns later, and advance the model.
  task automatic apply(input in_t x);
    drive(x);
    @(posedge clk);
    #1;
    model_step(x);
  endtask

  task automatic check_model(input string tag);
    check({tag, ".exc_valid"}, bus.exc_valid_dc3, m_dc3.fault);
    if (m_dc3.fault) begin
      check({tag, ".exc_store"}, bus.exc_store_dc3, m_dc3.store);
      check({tag, ".exc_mis"}, bus.exc_misaligned_dc3, m_dc3.mis);
      check({tag, ".exc_addr"}, bus.exc_addr_dc3, m_dc3.addr);
    end
    check({tag, ".err_valid"}, bus.err_valid, m_held);
    check({tag, ".err_cause"}, bus.err_cause, m_cause);
    check({tag, ".err_addr"}, bus.err_addr, m_addr);
    check({tag, ".ovf"}, bus.err_ovf_cnt, 64'(m_lost));
  endtask

  task automatic check_vec(input int idx, input exp_t e);
    string t;
    t = $sformatf("tbl%0d", idx);
    check({t, ".exc_valid"}, bus.exc_valid_dc3, e.exc);
    if (e.exc) begin
      check({t, ".exc_store"}, bus.exc_store_dc3, e.st);
      check({t, ".exc_mis"}, bus.exc_misaligned_dc3, e.mis);
      check({t, ".exc_addr"}, bus.exc_addr_dc3, e.a);
    end
    check({t, ".err_valid"}, bus.err_valid, e.ev);
    check({t, ".err_cause"}, bus.err_cause, e.cause);
    check({t, ".err_addr"}, bus.err_addr, e.ea);
    check({t, ".ovf"}, bus.err_ovf_cnt, e.ovf);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".exc_valid"}, bus.exc_valid_dc3, 0);
    check({tag, ".exc_addr"}, bus.exc_addr_dc3, 0);
    check({tag, ".err_valid"}, bus.err_valid, 0);
    check({tag, ".err_cause"}, bus.err_cause, 0);
    check({tag, ".err_addr"}, bus.err_addr, 0);
    check({tag, ".ovf"}, bus.err_ovf_cnt, 0);
  endtask

  vec_t tbl[$];

  initial begin
    // Directed vectors: inputs applied before an edge, outputs expected after it.
    // in:  v st dma acc mis addr          frz fl ack
    // ex:  exc st mis addr                ev cause err_addr ovf
    // Case 1: a load with an access fault.
    tbl.push_back('{mk_in(1,0,0,1,0,32'h6000_0002,0,0,0), mk_ex(0,0,0,0,            0,2'b00,32'h0,0)});
    tbl.push_back('{idle_in(),                            mk_ex(1,0,0,32'h6000_0002, 0,2'b00,32'h0,0)});
    tbl.push_back('{idle_in(),                            mk_ex(0,0,0,0,            1,2'b00,32'h6000_0002,0)});
    tbl.push_back('{mk_in(0,0,0,0,0,0,0,0,1),             mk_ex(0,0,0,0,            0,2'b00,32'h6000_0002,0)});
    // Case 2: a DMA store with both faults, then the same store as a non-DMA access.
    tbl.push_back('{mk_in(1,1,1,1,1,32'h7000_0001,0,0,0), mk_ex(0,0,0,0,            0,2'b00,32'h6000_0002,0)});
    tbl.push_back('{idle_in(),                            mk_ex(0,0,0,0,            0,2'b00,32'h6000_0002,0)});
    tbl.push_back('{idle_in(),                            mk_ex(0,0,0,0,            0,2'b00,32'h6000_0002,0)});
    tbl.push_back('{mk_in(1,1,0,1,1,32'h7000_0001,0,0,0), mk_ex(0,0,0,0,            0,2'b00,32'h6000_0002,0)});
    tbl.push_back('{idle_in(),                            mk_ex(1,1,0,32'h7000_0001, 0,2'b00,32'h6000_0002,0)});
    tbl.push_back('{idle_in(),                            mk_ex(0,0,0,0,            1,2'b10,32'h7000_0001,0)});
    tbl.push_back('{mk_in(0,0,0,0,0,0,0,0,1),             mk_ex(0,0,0,0,            0,2'b10,32'h7000_0001,0)});
    // Case 3: a misaligned store held in dc3 by three frozen cycles.
    tbl.push_back('{mk_in(1,1,0,0,1,32'h8000_0003,0,0,0), mk_ex(0,0,0,0,            0,2'b10,32'h7000_0001,0)});
    tbl.push_back('{idle_in(),                            mk_ex(1,1,1,32'h8000_0003, 0,2'b10,32'h7000_0001,0)});
    tbl.push_back('{mk_in(0,0,0,0,0,0,1,0,0),             mk_ex(1,1,1,32'h8000_0003, 0,2'b10,32'h7000_0001,0)});
    tbl.push_back('{mk_in(0,0,0,0,0,0,1,0,0),             mk_ex(1,1,1,32'h8000_0003, 0,2'b10,32'h7000_0001,0)});
    tbl.push_back('{mk_in(0,0,0,0,0,0,1,0,0),             mk_ex(1,1,1,32'h8000_0003, 0,2'b10,32'h7000_0001,0)});
    tbl.push_back('{idle_in(),                            mk_ex(0,0,0,0,            1,2'b11,32'h8000_0003,0)});
    tbl.push_back('{idle_in(),                            mk_ex(0,0,0,0,            1,2'b11,32'h8000_0003,0)});
    tbl.push_back('{mk_in(0,0,0,0,0,0,0,0,1),             mk_ex(0,0,0,0,            0,2'b11,32'h8000_0003,0)});
    // Case 4: a fault in dc2 with flush and freeze both asserted.
    tbl.push_back('{mk_in(1,0,0,1,0,32'h9000_0000,0,0,0), mk_ex(0,0,0,0,            0,2'b11,32'h8000_0003,0)});
    tbl.push_back('{mk_in(0,0,0,0,0,0,1,1,0),             mk_ex(0,0,0,0,            0,2'b11,32'h8000_0003,0)});
    tbl.push_back('{idle_in(),                            mk_ex(0,0,0,0,            0,2'b11,32'h8000_0003,0)});
    tbl.push_back('{idle_in(),                            mk_ex(0,0,0,0,            0,2'b11,32'h8000_0003,0)});

    rst = 1'b1;
    drive(idle_in());
    model_reset();
    #12;
    check_all_zero("reset");
    rst = 1'b0;

    foreach (tbl[k]) begin
      apply(tbl[k].i);
      check_vec(k, tbl[k].e);
      check_model($sformatf("tblm%0d", k));
    end

    // Eighteen back-to-back faults with no ack: the first is kept and the
    // other seventeen saturate the counter.
    for (int i = 0; i < 18; i++) begin
      apply(mk_in(1, 0, 0, 1, 0, 32'h0000_0A00 + 32'(i * 4), 0, 0, 0));
      check_model("burst");
    end
    apply(idle_in());
    apply(idle_in());
    check_model("burst_drain");
    check("burst.err_valid", bus.err_valid, 1);
    check("burst.err_addr", bus.err_addr, 32'h0000_0A00);
    check("burst.ovf_sat", bus.err_ovf_cnt, 4'hF);
    apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1));
    check("ack.err_valid", bus.err_valid, 0);
    check("ack.ovf_kept", bus.err_ovf_cnt, 4'hF);

    // An ack on the same edge as a new exception replaces the held error.
    apply(mk_in(1, 0, 0, 1, 0, 32'h2000_0000, 0, 0, 0));
    apply(idle_in());
    apply(idle_in());
    check("held.err_addr", bus.err_addr, 32'h2000_0000);
    apply(mk_in(1, 0, 0, 1, 0, 32'h0000_1000, 0, 0, 0));
    apply(idle_in());
    apply(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1));
    check("ackfire.err_valid", bus.err_valid, 1);
    check("ackfire.err_addr", bus.err_addr, 32'h0000_1000);
    check("ackfire.err_cause", bus.err_cause, 2'b00);
    check("ackfire.ovf", bus.err_ovf_cnt, 4'hF);
    check_model("ackfire");

    // Reset asserted mid-cycle with an exception pending clears everything at once.
    apply(mk_in(1, 1, 0, 0, 1, 32'h3000_0001, 0, 0, 0));
    apply(idle_in());
    check("pre_rst.exc_valid", bus.exc_valid_dc3, 1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    #3;
    rst = 1'b0;
    model_reset();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      in_t x;
      x.v   = ($urandom_range(0, 99) < 60);
      x.st  = $urandom_range(0, 1) == 1;
      x.dma = ($urandom_range(0, 99) < 10);
      x.acc = ($urandom_range(0, 99) < 35);
      x.mis = ($urandom_range(0, 99) < 35);
      x.a   = $urandom;
      x.frz = ($urandom_range(0, 99) < 20);
      x.fl  = ($urandom_range(0, 99) < 8);
      x.ack = ($urandom_range(0, 99) < 15);
      apply(x);
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_fault_pipe.md
Name: lsu_fault_pipe

Overview:
- Sits directly downstream of the LSU address-check stage.
- Takes the dc1 access-fault and misaligned-fault flags plus the start address, and stages them through dc2 and dc3 under freeze and flush control.
- Presents one precise LSU exception per instruction at dc3 to the TLU.
- Keeps a sticky first-error capture register, with an ack handshake and a saturating overflow counter, for debug/CSR readout.

Parameters:
- ADDR_WIDTH, 32, width of the captured fault address.
- OVF_CNT_WIDTH, 4, width of the saturating overflow counter.

Ports:
- clk  input  1  LSU clock.
- rst  input  1  asynchronous, active-high reset.
- lsu_freeze_dc3  input  1  pipeline hold; all stage registers keep their value.
- flush_dc2_dc3  input  1  kill the instructions in dc2 and dc3.
- valid_dc1  input  1  LSU packet valid in dc1.
- store_dc1  input  1  packet is a store.
- dma_dc1  input  1  packet is a DMA access; DMA never faults here.
- start_addr_dc1  input  ADDR_WIDTH  access start address.
- access_fault_dc1  input  1  access fault from address check.
- misaligned_fault_dc1  input  1  misaligned fault from address check.
- exc_valid_dc3  output  1  LSU exception pending at dc3.
- exc_store_dc3  output  1  1 = store/AMO fault, 0 = load fault.
- exc_misaligned_dc3  output  1  1 = misaligned, 0 = access fault.
- exc_addr_dc3  output  ADDR_WIDTH  faulting address (mtval).
- err_valid  output  1  capture register holds an error.
- err_cause  output  2  {store, misaligned} of the captured error.
- err_addr  output  ADDR_WIDTH  captured address.
- err_ack  input  1  consumer acknowledges the captured error.
- err_ovf_cnt  output  OVF_CNT_WIDTH  errors lost while the capture register was held.

Behaviour:
- Reset: every output and internal register is 0, and the capture FSM is IDLE. Reset is asynchronous on assertion and takes effect mid-operation; pending exceptions are dropped.
- dc1 qualify:
  - fault_dc1 = valid_dc1 & ~dma_dc1 & (access_fault_dc1 | misaligned_fault_dc1).
  - Access fault has priority: mis = misaligned_fault_dc1 & ~access_fault_dc1.
- Staging:
  - dc2 holds {fault, store, mis, addr}; dc3 holds the same fields.
  - Each clk edge with ~lsu_freeze_dc3: dc1 moves to dc2 and dc2 moves to dc3.
  - Latency: a dc1 fault appears on exc_*_dc3 exactly 2 edges later.
- Freeze: all stage registers hold. A dc3 exception stays asserted, stable, for every frozen cycle.
- Flush:
  - flush_dc2_dc3 clears the dc2 and dc3 fault bits at the next edge. dc1 still advances into dc2 unless frozen.
  - Flush beats freeze: the fault bits clear even when frozen.
  - Address fields need not be cleared.
- exc_valid_dc3 is the dc3 fault bit. exc_store_dc3, exc_misaligned_dc3 and exc_addr_dc3 are meaningful only while it is 1.
- exc_fire = exc_valid_dc3 & ~lsu_freeze_dc3 & ~flush_dc2_dc3. It is true exactly once per excepting instruction.
- Capture FSM: IDLE, HELD.
  - IDLE & exc_fire: load err_cause/err_addr, go to HELD.
  - IDLE & err_ack: ignored.
  - HELD & err_ack & ~exc_fire: go to IDLE. err_valid drops the next cycle; cause/addr keep their stale value.
  - HELD & err_ack & exc_fire: load the new error, stay HELD, no overflow.
  - HELD & ~err_ack & exc_fire: keep the old error and increment err_ovf_cnt, saturating at all-ones with no wrap.
  - err_ovf_cnt clears only on reset.
- err_valid = (state == HELD), registered.

Decomposition:
- Shared package, alongside the existing LSU types:
  - lsu_fault_t struct {fault, store, mis, addr[31:0]}.
  - Cause encodings: LSU_CAUSE_LD_ACC = 2'b00, LSU_CAUSE_LD_MIS = 2'b01, LSU_CAUSE_ST_ACC = 2'b10, LSU_CAUSE_ST_MIS = 2'b11.
- One sub-module is natural: lsu_fault_stage, a single pipeline register for lsu_fault_t with hold (freeze) and clear (flush). Instantiate it twice, for dc2 and dc3.
- Capture FSM and overflow counter stay in the top module.

Test Plan:
- Load at 0x6000_0002, access_fault=1, no freeze/flush -> exc_valid_dc3=1 two edges later with store=0, mis=0, addr=0x6000_0002. err_valid=1 the cycle after, err_cause=2'b00.
- Store with both faults=1 and dma_dc1=1 -> no exception. Same store with dma=0 -> exc_misaligned_dc3=0 (access priority), err_cause=2'b10.
- Misaligned store reaches dc3, then freeze for 3 cycles -> exc_valid_dc3 stays 1 and stable for 3 cycles. Capture happens only once, after freeze deasserts; err_ovf_cnt stays 0.
- Fault in dc2 with flush_dc2_dc3 and freeze both asserted -> exc_valid_dc3 never rises and err_valid stays 0.
- HELD with no ack, then 17 further faults -> err_addr keeps the first address and err_ovf_cnt saturates at 4'hF. Then err_ack alone -> err_valid=0 next cycle.
- HELD, then err_ack coincident with exc_fire at 0x0000_1000 -> stays HELD, err_addr=0x0000_1000, err_ovf_cnt unchanged. Assert rst mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
